// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory sequencer shared by instruction fetch and load/store data.
// Ports: clock/reset (async active-low); if_* fetch request/response; d_* data request/response;
// mem_* registered memory strobe, address, store data, plus read data and busy from memory;
// owner reports the current/last grant (0 fetch, 1 data).
// Optional MEM_TIMEOUT_EN: aborts a WAIT after TIMEOUT busy cycles with an err pulse.
module mem_arbiter #(
  parameter int NBITS = 8,
  parameter int MAX_STREAK = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [NBITS-1:0] if_addr,
  output logic [NBITS-1:0] if_rdata,
  output logic             if_ready,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [NBITS-1:0] d_addr,
  input  logic [NBITS-1:0] d_wdata,
  output logic [NBITS-1:0] d_rdata,
  output logic             d_ready,
  output logic             d_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_busy,
  output logic             owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam int SW = $clog2(MAX_STREAK + 1);
  state_t state_q, state_d;
  logic [NBITS-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [NBITS-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, we_q, we_d, owner_q, owner_d;
  logic if_ready_q, if_ready_d, d_ready_q, d_ready_d, if_err_q, if_err_d, d_err_q, d_err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic pick_d, tmo;
  // data wins unless a waiting fetch has already watched MAX_STREAK data grants
  assign pick_d = d_req && !(if_req && streak_q == SW'(MAX_STREAK));
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  assign tcnt_d = (state_q == ACCESS) ? '0 : (state_q == WAIT && mem_busy) ? tcnt_q + 1'b1 : tcnt_q;
  // fires on the TIMEOUT-th consecutive busy WAIT cycle
  assign tmo = state_q == WAIT && mem_busy && tcnt_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
`else
  assign tmo = TIMEOUT < 0;
`endif
  always_comb begin
    state_d = state_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    we_d = we_q;
    owner_d = owner_q;
    streak_d = streak_q;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    if_ready_d = 1'b0;
    d_ready_d = 1'b0;
    if_err_d = 1'b0;
    d_err_d = 1'b0;
    case (state_q)
      IDLE:
        if (if_req || d_req) begin
          state_d = ACCESS;
          owner_d = pick_d;
          mem_addr_d = pick_d ? d_addr : if_addr;
          mem_wdata_d = pick_d ? d_wdata : '0;
          we_d = pick_d && d_we;
          mem_en_d = 1'b1;
          mem_we_d = pick_d && d_we;
          streak_d = !pick_d ? '0 : (if_req && streak_q != SW'(MAX_STREAK)) ? streak_q + 1'b1 : streak_q;
        end
      ACCESS: state_d = WAIT;
      WAIT:
        if (!mem_busy) begin
          state_d = DONE;
          if_ready_d = !owner_q;
          d_ready_d = owner_q;
          if (!we_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else if_rdata_d = mem_rdata;
          end
        end else if (tmo) begin
          state_d = DONE;
          if_err_d = !owner_q;
          d_err_d = owner_q;
          if (owner_q) d_rdata_d = '0;
          else if_rdata_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      we_q <= 1'b0;
      owner_q <= 1'b0;
      streak_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      if_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
      we_q <= we_d;
      owner_q <= owner_d;
      streak_q <= streak_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      if_ready_q <= if_ready_d;
      d_ready_q <= d_ready_d;
      if_err_q <= if_err_d;
      d_err_q <= d_err_d;
    end
  end
  assign if_rdata = if_rdata_q;
  assign if_ready = if_ready_q;
  assign if_err = if_err_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign d_err = d_err_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic clock, reset;
  logic if_req, if_ready, if_err, d_req, d_we, d_ready, d_err;
  logic mem_en, mem_we, mem_busy, owner;
  logic [7:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0;
  int errors = 0;
  int n;
  logic seen;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(if_ready || d_ready || if_err || d_err) && cyc < 50);
    check("rdy_bound", 32'(cyc < 50), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, {if_rdata, d_rdata, mem_addr, mem_wdata},  0);
    check({tag, "_flags"}, {25'd0, if_ready, if_err, d_ready, d_err, mem_en, mem_we, owner}, 0);
  endtask

  initial begin
    reset = 1'b0;
    {if_req, d_req, d_we, mem_busy} = '0;
    {if_addr, d_addr, d_wdata, mem_rdata} = '0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b1;
    tick();
    // fetch only, no busy
    if_req = 1; if_addr = 8'h10; mem_rdata = 8'hA5;
    tick();
    check("f_access", {mem_en, mem_we, owner, mem_addr}, {3'b100, 8'h10});
    tick();
    check("f_wait_en", mem_en, 0);
    tick();
    check("f_done", {if_ready, d_ready, if_rdata}, {2'b10, 8'hA5});
    if_req = 0;
    tick();
    check("f_idle", if_ready, 0);
    // load to give d_rdata a known value
    d_req = 1; d_we = 0; d_addr = 8'h30; mem_rdata = 8'h5A;
    wait_rdy(n);
    check("ld_lat", n, 3);
    check("ld_done", {d_ready, owner, d_rdata}, {2'b11, 8'h5A});
    d_req = 0;
    tick();
    // store with 4 busy cycles, inputs changed after grant
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C; mem_busy = 1; mem_rdata = 8'h77;
    tick();
    check("st_access", {mem_en, mem_we, owner, mem_addr, mem_wdata}, {3'b111, 8'h20, 8'h3C});
    d_addr = 8'hFF; d_wdata = 8'hFF; d_we = 0;
    repeat (5) tick();
    check("st_busy", {d_ready, mem_en, mem_we}, 0);
    check("st_latched", {mem_addr, mem_wdata}, {8'h20, 8'h3C});
    mem_busy = 0;
    tick();
    check("st_done", {d_ready, d_rdata}, {1'b1, 8'h5A});
    d_req = 0;
    tick();
    check("st_idle", d_ready, 0);
    // simultaneous requests from a fresh reset
    reset = 0;
    tick();
    reset = 1;
    tick();
    if_req = 1; if_addr = 8'h50; d_req = 1; d_we = 0; d_addr = 8'h40; mem_rdata = 8'h11;
    tick();
    check("sim_d_grant", {owner, mem_addr}, {1'b1, 8'h40});
    tick();
    tick();
    check("sim_d_done", {d_ready, if_ready, d_rdata}, {2'b10, 8'h11});
    d_req = 0; mem_rdata = 8'h22;
    tick();
    tick();
    check("sim_f_grant", {owner, mem_en, mem_addr}, {2'b01, 8'h50});
    tick();
    tick();
    check("sim_f_done", {if_ready, d_ready, if_rdata}, {2'b10, 8'h22});
    if_req = 0;
    tick();
    // starvation guard: two rounds of 3 data grants then a fetch
    if_req = 1; d_req = 1; d_we = 0; mem_rdata = 8'h99;
    for (int i = 0; i < 8; i++) begin
      wait_rdy(n);
      check($sformatf("starve_%0d", i), {owner, d_ready, if_ready}, (i % 4 < 3) ? 3'b110 : 3'b001);
    end
    if_req = 0; d_req = 0;
    tick();
    // async reset mid-WAIT
    d_req = 1; d_we = 0; d_addr = 8'h44; mem_busy = 1;
    repeat (3) tick();
    reset = 0;
    #2;
    check_zero("areset");
    tick();
    reset = 1;
    d_req = 0; mem_busy = 0;
    seen = 0;
    repeat (10) begin
      tick();
      seen = seen | if_ready | d_ready | mem_en;
    end
    check("areset_quiet", seen, 0);
    // preload d_rdata then exercise a stuck busy
    d_req = 1; mem_rdata = 8'h66;
    wait_rdy(n);
    check("pre_tmo_ld", d_rdata, 8'h66);
    d_req = 0;
    tick();
    d_req = 1; d_we = 0; mem_busy = 1;
`ifdef MEM_TIMEOUT_EN
    wait_rdy(n);
    check("tmo_lat", n, 17);
    check("tmo_done", {d_err, d_ready, if_err, d_rdata}, {3'b100, 8'h00});
    d_req = 0;
    tick();
    check("tmo_pulse", d_err, 0);
`else
    seen = 0;
    repeat (100) begin
      tick();
      seen = seen | d_ready | d_err | if_err | if_ready;
    end
    check("no_tmo", {seen, d_rdata}, {1'b0, 8'h66});
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
